// File: rtl/color_pkg.sv
// Shared definitions for the colour-code digit path: palette, error codes
// and the decoder state encoding.
package color_pkg;

   // Palette, one 12-bit RGB 4:4:4 code per decimal digit
   localparam logic [11:0] COLOR_D0 = 12'h000;
   localparam logic [11:0] COLOR_D1 = 12'hF00;
   localparam logic [11:0] COLOR_D2 = 12'hF80;
   localparam logic [11:0] COLOR_D3 = 12'hFF0;
   localparam logic [11:0] COLOR_D4 = 12'h0F0;
   localparam logic [11:0] COLOR_D5 = 12'h0FF;
   localparam logic [11:0] COLOR_D6 = 12'h08F;
   localparam logic [11:0] COLOR_D7 = 12'h00F;
   localparam logic [11:0] COLOR_D8 = 12'hF0F;
   localparam logic [11:0] COLOR_D9 = 12'hFFF;

   typedef logic [1:0] err_t;

   localparam err_t ERR_OK      = 2'b00;
   localparam err_t ERR_CODE    = 2'b01;
   localparam err_t ERR_RANGE   = 2'b10;
   localparam err_t ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      S_TENS = 2'd0,
      S_ONES = 2'd1,
      S_OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/color_decoder_if.sv
// Colour-code input stream and decoded-number output stream of the decoder.
interface color_decoder_if;
   import color_pkg::*;

   logic [11:0] in_code;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  out_num;
   err_t        out_err;
   logic        out_valid;
   logic        out_ready;

   modport slave (
      input  in_code, in_valid, out_ready,
      output in_ready, out_num, out_err, out_valid
   );

   modport master (
      output in_code, in_valid, out_ready,
      input  in_ready, out_num, out_err, out_valid
   );

endinterface

// File: rtl/color_to_digit.sv
// Combinational palette lookup: 12-bit colour code to decimal digit.
module color_to_digit
   import color_pkg::*;
(
   input  logic [11:0] code,
   output logic [3:0]  digit,
   output logic        valid
);

   // Match the code against the palette; anything else is flagged invalid
   always_comb begin
      digit = 4'd0;
      valid = 1'b1;
      case (code)
         COLOR_D0: digit = 4'd0;
         COLOR_D1: digit = 4'd1;
         COLOR_D2: digit = 4'd2;
         COLOR_D3: digit = 4'd3;
         COLOR_D4: digit = 4'd4;
         COLOR_D5: digit = 4'd5;
         COLOR_D6: digit = 4'd6;
         COLOR_D7: digit = 4'd7;
         COLOR_D8: digit = 4'd8;
         COLOR_D9: digit = 4'd9;
         default:  valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/color_decoder.sv
// Reassembles a tens/ones pair of colour codes into a 6-bit number with an
// error status. A single lookup is shared by both digits since only one
// code can be accepted per cycle.
module color_decoder
   import color_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
)
(
   input  logic            clk,
   input  logic            rst_n,
   color_decoder_if.slave  bus
);

   state_t           state;
   state_t           state_next;
   logic [3:0]       tens;
   logic             bad;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       num_q;
   err_t             err_q;

   logic [3:0]       digit;
   logic             digit_ok;
   logic             xfer;
   logic             timeout_hit;
   logic [6:0]       value;

   color_to_digit u_lookup (
      .code  (bus.in_code),
      .digit (digit),
      .valid (digit_ok)
   );

   assign xfer        = bus.in_valid && bus.in_ready;
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
   assign value       = (7'(tens) << 3) + (7'(tens) << 1) + 7'(digit);

   assign bus.in_ready  = (state != S_OUT);
   assign bus.out_valid = (state == S_OUT);
   assign bus.out_num   = num_q;
   assign bus.out_err   = err_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_TENS;
      else        state <= state_next;
   end

   // Next state: a ones transfer takes precedence over an expiring timeout
   always_comb begin
      state_next = state;
      case (state)
         S_TENS: if (xfer) state_next = S_ONES;
         S_ONES: if (xfer || timeout_hit) state_next = S_OUT;
         S_OUT:  if (bus.out_ready) state_next = S_TENS;
         default: state_next = S_TENS;
      endcase
   end

   // Digit capture, inter-digit timer and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens  <= 4'd0;
         bad   <= 1'b0;
         cnt   <= '0;
         num_q <= 6'd0;
         err_q <= ERR_OK;
      end else begin
         case (state)
            S_TENS: begin
               if (xfer) begin
                  tens <= digit;
                  bad  <= !digit_ok;
                  cnt  <= '0;
               end
            end
            S_ONES: begin
               if (xfer) begin
                  if (bad || !digit_ok) begin
                     num_q <= 6'd0;
                     err_q <= ERR_CODE;
                  end else if (value > 7'd63) begin
                     num_q <= 6'd0;
                     err_q <= ERR_RANGE;
                  end else begin
                     num_q <= value[5:0];
                     err_q <= ERR_OK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  if (timeout_hit) begin
                     num_q <= 6'd0;
                     err_q <= ERR_TIMEOUT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_color_decoder.sv
// Directed scoreboard bench for color_decoder, built with a short timeout.
module tb_color_decoder;
   import color_pkg::*;

   typedef struct {
      logic [5:0] num;
      logic [1:0] err;
   } result_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   result_t sb[$];

   color_decoder_if ifc ();

   color_decoder #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_result(input logic [5:0] num, input logic [1:0] err);
      result_t r;
      r.num = num;
      r.err = err;
      sb.push_back(r);
   endtask

   task automatic send_code(input logic [11:0] code);
      int n = 0;
      logic done = 1'b0;
      ifc.in_code  = code;
      ifc.in_valid = 1'b1;
      while (!done && n < 10) begin
         done = (ifc.in_ready === 1'b1);
         @(posedge clk); #1;
         n++;
      end
      ifc.in_valid = 1'b0;
      check_val("accept", {7'd0, done}, 8'd1);
   endtask

   task automatic apply_stimulus(input logic [11:0] t, input logic [11:0] o,
                                 input logic [5:0] num, input logic [1:0] err);
      expect_result(num, err);
      send_code(t);
      send_code(o);
   endtask

   task automatic check_output(input string tag, input int hold);
      result_t r;
      r.num = 6'd0;
      r.err = 2'd0;
      check_val({tag, "_sb"}, (sb.size() > 0) ? 8'd1 : 8'd0, 8'd1);
      if (sb.size() > 0) r = sb.pop_front();
      check_val({tag, "_valid"}, {7'd0, ifc.out_valid}, 8'd1);
      check_val({tag, "_num"}, {2'd0, ifc.out_num}, {2'd0, r.num});
      check_val({tag, "_err"}, {6'd0, ifc.out_err}, {6'd0, r.err});
      for (int i = 0; i < hold; i++) begin
         ifc.out_ready = 1'b0;
         @(posedge clk); #1;
         check_val({tag, "_hold_valid"}, {7'd0, ifc.out_valid}, 8'd1);
         check_val({tag, "_hold_num"}, {2'd0, ifc.out_num}, {2'd0, r.num});
         check_val({tag, "_hold_rdy"}, {7'd0, ifc.in_ready}, 8'd0);
      end
      ifc.out_ready = 1'b1;
      @(posedge clk); #1;
      check_val({tag, "_drop"}, {7'd0, ifc.out_valid}, 8'd0);
      check_val({tag, "_inrdy"}, {7'd0, ifc.in_ready}, 8'd1);
   endtask

   // Directed sequence
   initial begin
      ifc.in_code   = 12'h000;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      #23;
      check_val("rst_valid", {7'd0, ifc.out_valid}, 8'd0);
      check_val("rst_num", {2'd0, ifc.out_num}, 8'd0);
      check_val("rst_err", {6'd0, ifc.out_err}, 8'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("rst_inrdy", {7'd0, ifc.in_ready}, 8'd1);

      apply_stimulus(12'hF80, 12'h0FF, 6'd25, ERR_OK);    check_output("n25", 0);
      apply_stimulus(12'h08F, 12'hF00, 6'd61, ERR_OK);    check_output("n61", 0);
      apply_stimulus(12'h08F, 12'hFF0, 6'd63, ERR_OK);    check_output("n63", 0);
      apply_stimulus(12'h08F, 12'h0FF, 6'd0, ERR_RANGE);  check_output("n65", 0);
      apply_stimulus(12'hFFF, 12'hFFF, 6'd0, ERR_RANGE);  check_output("n99", 0);
      apply_stimulus(12'h000, 12'h000, 6'd0, ERR_OK);     check_output("n00", 0);
      apply_stimulus(12'h123, 12'hFFF, 6'd0, ERR_CODE);   check_output("badt", 0);
      apply_stimulus(12'h08E, 12'h0FF, 6'd0, ERR_CODE);   check_output("badrng", 0);
      apply_stimulus(12'hF0F, 12'hABC, 6'd0, ERR_CODE);   check_output("bado", 0);

      // Tens only, then silence until the timer expires
      expect_result(6'd0, ERR_TIMEOUT);
      send_code(12'hFF0);
      for (int i = 0; i < 3; i++) begin
         check_val("to_wait", {7'd0, ifc.out_valid}, 8'd0);
         @(posedge clk); #1;
      end
      check_val("to_wait", {7'd0, ifc.out_valid}, 8'd0);
      @(posedge clk); #1;
      check_output("tmo", 0);

      // Ones accepted on the very cycle the timer would expire
      expect_result(6'd35, ERR_OK);
      send_code(12'hFF0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("late_wait", {7'd0, ifc.out_valid}, 8'd0);
      end
      send_code(12'h0FF);
      check_output("late", 0);

      // Consumer stalls for five cycles
      apply_stimulus(12'h0F0, 12'hF0F, 6'd48, ERR_OK);
      check_output("bp", 5);

      // Reset while waiting for the ones digit
      send_code(12'hF0F);
      rst_n = 1'b0;
      #2;
      check_val("mid_valid", {7'd0, ifc.out_valid}, 8'd0);
      check_val("mid_err", {6'd0, ifc.out_err}, 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_val("mid_inrdy", {7'd0, ifc.in_ready}, 8'd1);
      apply_stimulus(12'h0F0, 12'h00F, 6'd47, ERR_OK);
      check_output("n47", 0);

      check_val("sb_empty", 8'(sb.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
